// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronise/debounce door, window, fire sensors and stability-filter the temperature bus
// Optional feature macro: FIRE_FAST_EN (undebounced SFA rising edge).
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SAMPLE_DIV      = 8,
  parameter int TEMP_STABLE     = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD_raw,
  input  logic       SRD_raw,
  input  logic       SW_raw,
  input  logic       SFA_raw,
  input  logic [6:0] ST_raw,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [6:0] ST,
  output logic       temp_valid,
  output logic       evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(TEMP_STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(TEMP_STABLE);

  // Sensor vector order: {SFA, SW, SRD, SFD}
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    clean;
  logic [3:0]    clean_nxt;
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];

  logic [6:0]    st_s1;
  logic [6:0]    st_s2;
  logic [6:0]    last;
  logic [6:0]    last_nxt;
  logic [6:0]    st_q;
  logic [6:0]    st_nxt;
  logic [PW-1:0] pre;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          tick;
  logic          valid_q;
  logic          valid_nxt;
  logic          evt_q;
  logic          evt_nxt;

  assign raw = {SFA_raw, SW_raw, SRD_raw, SFD_raw};
  assign {SFA, SW, SRD, SFD} = clean;
  assign ST         = st_q;
  assign temp_valid = valid_q;
  assign evt        = evt_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clean_nxt[i] = clean[i];
      cnt_nxt[i]   = '0;
      if (sync2[i] != clean[i]) begin
        if (cnt[i] == CNT_LAST) begin
          clean_nxt[i] = ~clean[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
`ifdef FIRE_FAST_EN
    // Alarm rise is taken as the second sync flop loads, skipping the debounce window.
    if (!clean[3] && sync1[3]) begin
      clean_nxt[3] = 1'b1;
      cnt_nxt[3]   = '0;
    end
`endif
  end

  always_comb begin
    tick      = (pre == PRE_LAST);
    last_nxt  = last;
    run_nxt   = run;
    st_nxt    = st_q;
    valid_nxt = valid_q;
    if (tick) begin
      if (run == '0 || st_s2 != last) begin
        last_nxt = st_s2;
        run_nxt  = RW'(1);
      end else if (run != RUN_MAX) begin
        run_nxt = run + RW'(1);
      end
      if (run_nxt == RUN_MAX) begin
        st_nxt    = st_s2;
        valid_nxt = 1'b1;
      end
    end
    // temp_valid alone never raises evt; only visible value changes do.
    evt_nxt = (clean_nxt != clean) || (st_nxt != st_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1   <= '0;
      sync2   <= '0;
      clean   <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      st_s1   <= '0;
      st_s2   <= '0;
      pre     <= '0;
      run     <= '0;
      last    <= '0;
      st_q    <= '0;
      valid_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      clean   <= clean_nxt;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      st_s1   <= ST_raw;
      st_s2   <= st_s1;
      pre     <= tick ? '0 : pre + PW'(1);
      run     <= run_nxt;
      last    <= last_nxt;
      st_q    <= st_nxt;
      valid_q <= valid_nxt;
      evt_q   <= evt_nxt;
    end
  end

endmodule
